// File: rtl/request_encoder_16to4_pkg.sv
// Shared constants for the request encoder: widths and FSM state encodings.
package request_encoder_16to4_pkg;

    localparam int unsigned N_REQ  = 16;
    localparam int unsigned CODE_W = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/request_encoder_16to4_lsb_priority_encoder16.sv
// Combinational lowest-set-index search over a 16-bit vector.
module lsb_priority_encoder16 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_index,
    output logic        o_any
);
    import request_encoder_16to4_pkg::*;

    always_comb begin
        o_index = '0;
        o_any   = |i_vec;
        // Walk from the top so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/request_encoder_16to4.sv
// Captures request pulses into a pending set and grants them one at a time,
// lowest index first, holding each code until the consumer acknowledges it.
module request_encoder_16to4 #(
    parameter int unsigned N_REQ  = request_encoder_16to4_pkg::N_REQ,
    parameter int unsigned CODE_W = request_encoder_16to4_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  i_req,
    input  logic              i_ack,
    output logic [CODE_W-1:0] o_code,
    output logic              o_valid,
    output logic [N_REQ-1:0]  o_pending,
    output logic              o_busy
);
    import request_encoder_16to4_pkg::*;

    logic [0:0]        r_state;
    logic [0:0]        w_state_d;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_d;
    logic              r_valid;
    logic              w_valid_d;
    logic [N_REQ-1:0]  r_pending;
    logic [N_REQ-1:0]  w_pending_d;
    logic [N_REQ-1:0]  w_clr;
    logic [CODE_W-1:0] w_index;
    logic              w_any;

    lsb_priority_encoder16 u_lsb_enc (
        .i_vec   (r_pending),
        .o_index (w_index),
        .o_any   (w_any)
    );

    // A new request on the bit being cleared wins, so it stays pending.
    always_comb begin
        w_clr = '0;
        if (r_valid && i_ack) begin
            w_clr = N_REQ'(1) << r_code;
        end
        w_pending_d = (r_pending & ~w_clr) | i_req;
    end

    always_comb begin
        w_state_d = r_state;
        w_code_d  = r_code;
        w_valid_d = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_code_d  = w_index;
                    w_valid_d = 1'b1;
                    w_state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (i_ack) begin
                    w_valid_d = 1'b0;
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_valid_d = 1'b0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_d;
            r_code    <= w_code_d;
            r_valid   <= w_valid_d;
            r_pending <= w_pending_d;
        end
    end

    assign o_code    = r_code;
    assign o_valid   = r_valid;
    assign o_pending = r_pending;
    assign o_busy    = r_valid | (|r_pending);

endmodule
